// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions used by fetch and decode: XLEN, the canonical NOP,
// the default boot PC, major opcodes and the fetch buffer entry layout.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0100_0000;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Instruction fetch is word granular; the low address bits are simply dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer: power-of-two depth, head is read straight from storage.
// Flush empties the buffer and wins over a push in the same cycle.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                         i_clock,
    input  logic                         i_reset_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic [WIDTH-1:0]             o_head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] L_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && (r_count != L_FULL) && !i_flush;
    assign w_do_pop  = i_pop && (r_count != '0) && !i_flush;

    always_ff @(posedge i_clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word reads and buffers
// returned words with their PCs for decode. Redirects flush and drop in-flight responses.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_resp_valid,
    input  logic [XLEN-1:0]  imem_resp_data,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             stall,
    output logic             f_valid,
    output logic [XLEN-1:0]  f_pc,
    output logic [XLEN-1:0]  inst
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] L_DEPTH = (CNT_W+1)'(FIFO_DEPTH);

    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_ret_pc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [CNT_W-1:0] w_count;
    logic [CNT_W:0]   w_inflight;
    logic [XLEN-1:0]  w_redirect_pc;
    fetch_entry_t     w_head;
    fetch_entry_t     w_push_entry;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;

    assign w_redirect_pc = align_pc(redirect_pc);

    // Buffered plus in-flight words never exceed the buffer, so responses need no backpressure.
    assign w_inflight     = {1'b0, w_count} + {1'b0, r_outstanding};
    assign imem_req_valid = reset_n && !redirect_valid && (w_inflight < L_DEPTH);
    assign imem_req_addr  = r_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    assign w_push       = imem_resp_valid && (r_drop_cnt == '0) && !redirect_valid;
    assign w_push_entry = '{pc: r_ret_pc, inst: imem_resp_data};
    assign f_valid      = (w_count != '0);
    assign w_pop        = f_valid && !stall && !redirect_valid;

    assign f_pc = f_valid ? w_head.pc   : '0;
    assign inst = f_valid ? w_head.inst : NOP_INST;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc     <= RESET_PC;
            r_ret_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc     <= w_redirect_pc;
            r_ret_pc <= w_redirect_pc;
        end else begin
            if (w_accept) begin
                r_pc <= r_pc + XLEN'(4);
            end
            if (w_push) begin
                r_ret_pc <= r_ret_pc + XLEN'(4);
            end
        end
    end

    // A response arriving in the redirect cycle is itself discarded, hence the subtraction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            case ({w_accept, imem_resp_valid})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            if (redirect_valid) begin
                r_drop_cnt <= r_outstanding - CNT_W'(imem_resp_valid);
            end else if (imem_resp_valid && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - CNT_W'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .i_clock   (clock),
        .i_reset_n (reset_n),
        .i_push    (w_push),
        .i_data    (w_push_entry),
        .i_pop     (w_pop),
        .i_flush   (redirect_valid),
        .o_count   (w_count),
        .o_head    (w_head)
    );

endmodule
